// File: rtl/cbi980_fifo_bank_if.sv
// Bundles the host-side register port and the line-side serialiser
// signals of the cbi980 channel FIFO bank.
//   master : driver side (register front-end and serialisers)
//   slave  : the FIFO bank itself
// Signals:
//   flush                                     soft reset of all FIFOs and sticky flags
//   host_wr_ch/_data/_en, host_wr_err         host push into a TX FIFO
//   host_rd_ch/_en, host_rd_data/_valid       host pop from an RX FIFO
//   line_rx_data/_push                        per-channel RX words from the line side
//   line_tx_data/_pop                         per-channel TX head words (fall-through)
//   status, ie, flag_clr, interrupt           per-channel status, enables, clears, irq
interface cbi980_fifo_bank_if #(
  parameter int CHANNELS = 2,
  parameter int DW       = 32,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                   flush;
  logic [CW-1:0]          host_wr_ch;
  logic [DW-1:0]          host_wr_data;
  logic                   host_wr_en;
  logic                   host_wr_err;
  logic [CW-1:0]          host_rd_ch;
  logic                   host_rd_en;
  logic [DW-1:0]          host_rd_data;
  logic                   host_rd_valid;
  logic [CHANNELS*DW-1:0] line_rx_data;
  logic [CHANNELS-1:0]    line_rx_push;
  logic [CHANNELS*DW-1:0] line_tx_data;
  logic [CHANNELS-1:0]    line_tx_pop;
  logic [CHANNELS*6-1:0]  status;
  logic [CHANNELS*6-1:0]  ie;
  logic [CHANNELS*2-1:0]  flag_clr;
  logic                   interrupt;

  modport master (
    output flush, host_wr_ch, host_wr_data, host_wr_en, host_rd_ch, host_rd_en,
           line_rx_data, line_rx_push, line_tx_pop, ie, flag_clr,
    input  host_wr_err, host_rd_data, host_rd_valid, line_tx_data, status, interrupt
  );

  modport slave (
    input  flush, host_wr_ch, host_wr_data, host_wr_en, host_rd_ch, host_rd_en,
           line_rx_data, line_rx_push, line_tx_pop, ie, flag_clr,
    output host_wr_err, host_rd_data, host_rd_valid, line_tx_data, status, interrupt
  );
endinterface

// File: rtl/cbi980_fifo_bank.sv
// Channel FIFO bank for the cbi980 serial audio core: one RX and one TX FIFO
// per channel between the register front-end and the per-channel serialisers,
// with per-channel status, sticky rx_ovf/tx_unf flags and a masked interrupt.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  cbi980_fifo_bank_if.slave (host, line, status and interrupt signals)
// Per-channel status layout at [c*6 +: 6] = {rx_ovf, tx_unf, rxne, rxf, txnf, txe}.
module cbi980_fifo_bank #(
  parameter int CHANNELS = 2,
  parameter int DW       = 32,
  parameter int DEPTH_LG = 4
) (
  input logic               clk,
  input logic               rst,
  cbi980_fifo_bank_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LG;
  localparam logic [DEPTH_LG:0] FULL_CNT = (DEPTH_LG + 1)'(DEPTH);

  logic [DW-1:0]       tx_mem  [CHANNELS][DEPTH];
  logic [DW-1:0]       rx_mem  [CHANNELS][DEPTH];
  logic [DEPTH_LG-1:0] tx_head [CHANNELS];
  logic [DEPTH_LG-1:0] tx_tail [CHANNELS];
  logic [DEPTH_LG-1:0] rx_head [CHANNELS];
  logic [DEPTH_LG-1:0] rx_tail [CHANNELS];
  logic [DEPTH_LG:0]   tx_cnt  [CHANNELS];
  logic [DEPTH_LG:0]   rx_cnt  [CHANNELS];
  logic [CHANNELS-1:0] tx_unf, rx_ovf;

  logic [CHANNELS-1:0] tx_push, tx_pop, tx_unf_set;
  logic [CHANNELS-1:0] rx_push, rx_pop, rx_ovf_set;
  logic                wr_ch_ok, rd_ch_ok;
  logic [DW-1:0]       rd_word;

  // Accept/reject decisions for every FIFO, based on counts before the edge.
  // A full FIFO still accepts a push when the opposite side pops it in the
  // same cycle; a pop is only honoured when the FIFO already holds a word.
  always_comb begin
    wr_ch_ok         = int'(bus.host_wr_ch) < CHANNELS;
    rd_ch_ok         = int'(bus.host_rd_ch) < CHANNELS;
    tx_push          = '0;
    tx_pop           = '0;
    tx_unf_set       = '0;
    rx_push          = '0;
    rx_pop           = '0;
    rx_ovf_set       = '0;
    rd_word          = '0;
    bus.status       = '0;
    bus.line_tx_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tx_pop[c]     = bus.line_tx_pop[c] && (tx_cnt[c] != '0);
      tx_unf_set[c] = bus.line_tx_pop[c] && (tx_cnt[c] == '0);
      tx_push[c]    = bus.host_wr_en && wr_ch_ok && (int'(bus.host_wr_ch) == c) &&
                      ((tx_cnt[c] != FULL_CNT) || tx_pop[c]);
      rx_pop[c]     = bus.host_rd_en && rd_ch_ok && (int'(bus.host_rd_ch) == c) &&
                      (rx_cnt[c] != '0);
      rx_push[c]    = bus.line_rx_push[c] && ((rx_cnt[c] != FULL_CNT) || rx_pop[c]);
      rx_ovf_set[c] = bus.line_rx_push[c] && !rx_push[c];
      if (rx_pop[c]) rd_word = rx_mem[c][rx_tail[c]];
      if (tx_cnt[c] != '0) bus.line_tx_data[c*DW +: DW] = tx_mem[c][tx_tail[c]];
      bus.status[c*6 +: 6] = {rx_ovf[c], tx_unf[c], rx_cnt[c] != '0,
                              rx_cnt[c] == FULL_CNT, tx_cnt[c] != FULL_CNT,
                              tx_cnt[c] == '0};
    end
    // Any write that did not land in a FIFO is reported as an error.
    bus.host_wr_err = bus.host_wr_en && !(|tx_push);
  end

  // Storage has no reset; only pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (tx_push[c] && !bus.flush) tx_mem[c][tx_head[c]] <= bus.host_wr_data;
      if (rx_push[c] && !bus.flush) rx_mem[c][rx_head[c]] <= bus.line_rx_data[c*DW +: DW];
    end
  end

  // Pointers, counts, sticky flags and the registered host read / interrupt.
  // flush overrides every push, pop and clear; a flag set beats its clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        tx_head[c] <= '0;
        tx_tail[c] <= '0;
        tx_cnt[c]  <= '0;
        rx_head[c] <= '0;
        rx_tail[c] <= '0;
        rx_cnt[c]  <= '0;
      end
      tx_unf            <= '0;
      rx_ovf            <= '0;
      bus.host_rd_data  <= '0;
      bus.host_rd_valid <= 1'b0;
      bus.interrupt     <= 1'b0;
    end else begin
      bus.interrupt     <= |(bus.status & bus.ie);
      bus.host_rd_valid <= !bus.flush && (|rx_pop);
      if (!bus.flush && (|rx_pop)) bus.host_rd_data <= rd_word;
      if (bus.flush) begin
        for (int c = 0; c < CHANNELS; c++) begin
          tx_head[c] <= '0;
          tx_tail[c] <= '0;
          tx_cnt[c]  <= '0;
          rx_head[c] <= '0;
          rx_tail[c] <= '0;
          rx_cnt[c]  <= '0;
        end
        tx_unf <= '0;
        rx_ovf <= '0;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (tx_push[c]) tx_head[c] <= tx_head[c] + DEPTH_LG'(1);
          if (tx_pop[c])  tx_tail[c] <= tx_tail[c] + DEPTH_LG'(1);
          if (rx_push[c]) rx_head[c] <= rx_head[c] + DEPTH_LG'(1);
          if (rx_pop[c])  rx_tail[c] <= rx_tail[c] + DEPTH_LG'(1);
          tx_cnt[c] <= tx_cnt[c] + (DEPTH_LG + 1)'(tx_push[c]) - (DEPTH_LG + 1)'(tx_pop[c]);
          rx_cnt[c] <= rx_cnt[c] + (DEPTH_LG + 1)'(rx_push[c]) - (DEPTH_LG + 1)'(rx_pop[c]);
          tx_unf[c] <= tx_unf_set[c] | (tx_unf[c] & !bus.flag_clr[c*2]);
          rx_ovf[c] <= rx_ovf_set[c] | (rx_ovf[c] & !bus.flag_clr[c*2+1]);
        end
      end
    end
  end
endmodule
